// File: rtl/core_mem_responder_if.sv
// Core-side memory bus: program read, data read and data write valid/ready
// channels between one compute core and its memory responder.
interface core_mem_responder_if #(
  parameter int DATA_MEM_ADDR_BITS    = 8,
  parameter int DATA_MEM_DATA_BITS    = 8,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 32
);

  logic                             program_mem_read_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] program_mem_read_address;
  logic                             program_mem_read_ready;
  logic [PROGRAM_MEM_DATA_BITS-1:0] program_mem_read_data;

  logic                             data_mem_read_valid;
  logic [DATA_MEM_ADDR_BITS-1:0]    data_mem_read_address;
  logic                             data_mem_read_ready;
  logic [DATA_MEM_DATA_BITS-1:0]    data_mem_read_data;

  logic                             data_mem_write_valid;
  logic [DATA_MEM_ADDR_BITS-1:0]    data_mem_write_address;
  logic [DATA_MEM_DATA_BITS-1:0]    data_mem_write_data;
  logic                             data_mem_write_ready;

  // The core issues requests and consumes responses.
  modport master (
    output program_mem_read_valid,
    output program_mem_read_address,
    input  program_mem_read_ready,
    input  program_mem_read_data,
    output data_mem_read_valid,
    output data_mem_read_address,
    input  data_mem_read_ready,
    input  data_mem_read_data,
    output data_mem_write_valid,
    output data_mem_write_address,
    output data_mem_write_data,
    input  data_mem_write_ready
  );

  // The memory responder accepts requests and produces responses.
  modport slave (
    input  program_mem_read_valid,
    input  program_mem_read_address,
    output program_mem_read_ready,
    output program_mem_read_data,
    input  data_mem_read_valid,
    input  data_mem_read_address,
    output data_mem_read_ready,
    output data_mem_read_data,
    input  data_mem_write_valid,
    input  data_mem_write_address,
    input  data_mem_write_data,
    output data_mem_write_ready
  );

endinterface

// File: rtl/core_mem_responder.sv
// Memory-side responder for one compute core. Holds a program array and a
// data array, serves three independent valid/ready channels after fixed
// per-channel latencies, and exposes a host port for preloading both arrays.
module core_mem_responder #(
  parameter int DATA_MEM_ADDR_BITS    = 8,
  parameter int DATA_MEM_DATA_BITS    = 8,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 32,
  parameter int PROG_LATENCY          = 2,
  parameter int READ_LATENCY          = 2,
  parameter int WRITE_LATENCY         = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  core_mem_responder_if.slave              mem_if,
  input  logic                             host_en,
  input  logic                             host_sel,
  input  logic                             host_we,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] host_addr,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] host_wdata,
  output logic                             busy
);

  localparam int NUM_CH  = 3;
  localparam int CH_PROG = 0;
  localparam int CH_RD   = 1;
  localparam int CH_WR   = 2;

  localparam int LAT_PR  = (PROG_LATENCY > READ_LATENCY) ? PROG_LATENCY : READ_LATENCY;
  localparam int LAT_MAX = (LAT_PR > WRITE_LATENCY) ? LAT_PR : WRITE_LATENCY;
  localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_DROP
  } state_t;

  // Counter preload for each channel: the acceptance edge counts as the
  // first cycle of latency, so the counter starts at LATENCY-1.
  function automatic logic [CW-1:0] latency_load(input int ch);
    case (ch)
      CH_PROG: return CW'(PROG_LATENCY - 1);
      CH_RD:   return CW'(READ_LATENCY - 1);
      default: return CW'(WRITE_LATENCY - 1);
    endcase
  endfunction

  // Storage; contents survive reset.
  logic [PROGRAM_MEM_DATA_BITS-1:0] program_mem [2**PROGRAM_MEM_ADDR_BITS];
  logic [DATA_MEM_DATA_BITS-1:0]    data_mem    [2**DATA_MEM_ADDR_BITS];

  // Per-channel control state.
  state_t          ch_state_q [NUM_CH];
  state_t          ch_state_d [NUM_CH];
  logic [CW-1:0]   ch_cnt_q   [NUM_CH];
  logic [CW-1:0]   ch_cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_accept;
  logic [NUM_CH-1:0] ch_commit;

  // Captured request fields and registered read responses.
  logic [PROGRAM_MEM_ADDR_BITS-1:0] prog_addr_q, prog_addr_d;
  logic [DATA_MEM_ADDR_BITS-1:0]    rd_addr_q, rd_addr_d;
  logic [DATA_MEM_ADDR_BITS-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_MEM_DATA_BITS-1:0]    wr_data_q, wr_data_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0] prog_data_q, prog_data_d;
  logic [DATA_MEM_DATA_BITS-1:0]    rd_data_q, rd_data_d;

  // Host port decode.
  logic                             host_prog_we;
  logic                             host_data_we;
  logic [DATA_MEM_ADDR_BITS-1:0]    host_data_addr;
  logic [DATA_MEM_DATA_BITS-1:0]    host_data_wdata;

  // Words the read channels would sample this cycle, after write-first bypass.
  logic [PROGRAM_MEM_DATA_BITS-1:0] prog_word;
  logic [DATA_MEM_DATA_BITS-1:0]    rd_word;

  assign ch_valid = {mem_if.data_mem_write_valid,
                     mem_if.data_mem_read_valid,
                     mem_if.program_mem_read_valid};

  assign host_prog_we    = host_en & host_we & host_sel;
  assign host_data_we    = host_en & host_we & ~host_sel;
  assign host_data_addr  = host_addr[DATA_MEM_ADDR_BITS-1:0];
  assign host_data_wdata = host_wdata[DATA_MEM_DATA_BITS-1:0];

  // Channel FSMs: accept when idle and the host does not own the memories,
  // count down the latency, pulse ready for one cycle, then wait for the
  // core to drop valid so a held request is never served twice.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_state_d[i] = ch_state_q[i];
      ch_cnt_d[i]   = ch_cnt_q[i];
      ch_accept[i]  = 1'b0;
      ch_commit[i]  = 1'b0;
      case (ch_state_q[i])
        ST_IDLE: begin
          if (ch_valid[i] && !host_en) begin
            ch_state_d[i] = ST_WAIT;
            ch_cnt_d[i]   = latency_load(i);
            ch_accept[i]  = 1'b1;
          end
        end
        ST_WAIT: begin
          if (ch_cnt_q[i] == '0) begin
            ch_state_d[i] = ST_RESP;
            ch_commit[i]  = 1'b1;
          end else begin
            ch_cnt_d[i] = ch_cnt_q[i] - CW'(1);
          end
        end
        ST_RESP: begin
          ch_state_d[i] = ST_DROP;
        end
        ST_DROP: begin
          if (!ch_valid[i]) begin
            ch_state_d[i] = ST_IDLE;
          end
        end
        default: begin
          ch_state_d[i] = ST_IDLE;
          ch_cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Channel state and latency counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_state_q[i] <= ST_IDLE;
        ch_cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_state_q[i] <= ch_state_d[i];
        ch_cnt_q[i]   <= ch_cnt_d[i];
      end
    end
  end

  // Read sample words: a write committing on the same edge as the sample is
  // forwarded, and a core write beats a host write to the same data address.
  always_comb begin
    prog_word = program_mem[prog_addr_q];
    if (host_prog_we && (host_addr == prog_addr_q)) begin
      prog_word = host_wdata;
    end
    rd_word = data_mem[rd_addr_q];
    if (host_data_we && (host_data_addr == rd_addr_q)) begin
      rd_word = host_data_wdata;
    end
    if (ch_commit[CH_WR] && (wr_addr_q == rd_addr_q)) begin
      rd_word = wr_data_q;
    end
  end

  // Request capture at acceptance and response data that is non-zero only
  // during the ready cycle.
  always_comb begin
    prog_addr_d = ch_accept[CH_PROG] ? mem_if.program_mem_read_address : prog_addr_q;
    rd_addr_d   = ch_accept[CH_RD]   ? mem_if.data_mem_read_address    : rd_addr_q;
    wr_addr_d   = ch_accept[CH_WR]   ? mem_if.data_mem_write_address   : wr_addr_q;
    wr_data_d   = ch_accept[CH_WR]   ? mem_if.data_mem_write_data      : wr_data_q;
    prog_data_d = ch_commit[CH_PROG] ? prog_word : '0;
    rd_data_d   = ch_commit[CH_RD]   ? rd_word   : '0;
  end

  // Capture and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_addr_q <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      prog_data_q <= '0;
      rd_data_q   <= '0;
    end else begin
      prog_addr_q <= prog_addr_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      prog_data_q <= prog_data_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Program array: written only from the host port.
  always_ff @(posedge clk) begin
    if (host_prog_we) begin
      program_mem[host_addr] <= host_wdata;
    end
  end

  // Data array: host write first, core commit last so the core wins a tie.
  always_ff @(posedge clk) begin
    if (host_data_we) begin
      data_mem[host_data_addr] <= host_data_wdata;
    end
    if (ch_commit[CH_WR]) begin
      data_mem[wr_addr_q] <= wr_data_q;
    end
  end

  // Bus outputs and aggregate activity flag.
  always_comb begin
    mem_if.program_mem_read_ready = (ch_state_q[CH_PROG] == ST_RESP);
    mem_if.program_mem_read_data  = prog_data_q;
    mem_if.data_mem_read_ready    = (ch_state_q[CH_RD] == ST_RESP);
    mem_if.data_mem_read_data     = rd_data_q;
    mem_if.data_mem_write_ready   = (ch_state_q[CH_WR] == ST_RESP);
    busy = (ch_state_q[CH_PROG] != ST_IDLE) ||
           (ch_state_q[CH_RD]   != ST_IDLE) ||
           (ch_state_q[CH_WR]   != ST_IDLE);
  end

endmodule

// File: tb/tb_core_mem_responder.sv
// Randomized scoreboard bench for core_mem_responder: drivers push expected
// responses (data and due cycle) from a simple array model, and a monitor
// compares them whenever a ready pulse appears.
module tb_core_mem_responder;

  localparam int PL = 2;
  localparam int RL = 2;
  localparam int WL = 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_en, host_sel, host_we;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t q_prog[$];
  exp_t q_rd[$];
  exp_t q_wr[$];

  logic [31:0] prog_ref [256];
  logic [7:0]  data_ref [256];

  core_mem_responder_if #(
    .DATA_MEM_ADDR_BITS(8), .DATA_MEM_DATA_BITS(8),
    .PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(32)
  ) mem_if ();

  core_mem_responder #(
    .DATA_MEM_ADDR_BITS(8), .DATA_MEM_DATA_BITS(8),
    .PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(32),
    .PROG_LATENCY(PL), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_if(mem_if),
    .host_en(host_en),
    .host_sel(host_sel),
    .host_we(host_we),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation on every ready pulse; checks read data is
  // zero outside ready cycles and flags pulses nobody asked for.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_if.program_mem_read_ready) begin
          if (q_prog.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL prog_unexpected_ready: got ready=1, expected no pulse (cycle %0d)", cyc);
          end else begin
            e = q_prog.pop_front();
            check_output("prog_data", mem_if.program_mem_read_data, e.data);
            check_output("prog_latency", 32'(cyc), 32'(e.due));
          end
        end else begin
          check_output("prog_data_idle", mem_if.program_mem_read_data, 32'h0);
        end
        if (mem_if.data_mem_read_ready) begin
          if (q_rd.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL rd_unexpected_ready: got ready=1, expected no pulse (cycle %0d)", cyc);
          end else begin
            e = q_rd.pop_front();
            check_output("rd_data", {24'h0, mem_if.data_mem_read_data}, e.data);
            check_output("rd_latency", 32'(cyc), 32'(e.due));
          end
        end else begin
          check_output("rd_data_idle", {24'h0, mem_if.data_mem_read_data}, 32'h0);
        end
        if (mem_if.data_mem_write_ready) begin
          if (q_wr.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL wr_unexpected_ready: got ready=1, expected no pulse (cycle %0d)", cyc);
          end else begin
            e = q_wr.pop_front();
            check_output("wr_latency", 32'(cyc), 32'(e.due));
          end
        end
      end
    end
  end

  function automatic logic ch_ready(input int ch);
    case (ch)
      0:       return mem_if.program_mem_read_ready;
      1:       return mem_if.data_mem_read_ready;
      default: return mem_if.data_mem_write_ready;
    endcase
  endfunction

  // Waits (bounded) for the channel's ready pulse while scrambling the
  // request fields, keeps valid held two more cycles, then drops it.
  task automatic finish_request(input int ch);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = ch_ready(ch);
      case (ch)
        0: mem_if.program_mem_read_address = 8'($urandom);
        1: mem_if.data_mem_read_address    = 8'($urandom);
        default: begin
          mem_if.data_mem_write_address = 8'($urandom);
          mem_if.data_mem_write_data    = 8'($urandom);
        end
      endcase
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL ready_timeout: channel %0d got no ready, expected one within 40 cycles", ch);
    end
    repeat (2) @(negedge clk);
    case (ch)
      0:       mem_if.program_mem_read_valid = 1'b0;
      1:       mem_if.data_mem_read_valid    = 1'b0;
      default: mem_if.data_mem_write_valid   = 1'b0;
    endcase
  endtask

  task automatic do_prog_read(input logic [7:0] a);
    exp_t e;
    @(negedge clk);
    mem_if.program_mem_read_valid   = 1'b1;
    mem_if.program_mem_read_address = a;
    e.data = prog_ref[a];
    e.due  = cyc + 1 + PL;
    q_prog.push_back(e);
    finish_request(0);
  endtask

  task automatic do_data_read(input logic [7:0] a, input logic [7:0] expv);
    exp_t e;
    @(negedge clk);
    mem_if.data_mem_read_valid   = 1'b1;
    mem_if.data_mem_read_address = a;
    e.data = {24'h0, expv};
    e.due  = cyc + 1 + RL;
    q_rd.push_back(e);
    finish_request(1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    mem_if.data_mem_write_valid   = 1'b1;
    mem_if.data_mem_write_address = a;
    mem_if.data_mem_write_data    = d;
    e.data = 32'h0;
    e.due  = cyc + 1 + WL;
    q_wr.push_back(e);
    finish_request(2);
  endtask

  // Write and read overlapped; the read is accepted d cycles after the write.
  // The read sees the new value when the write commits no later than the
  // edge on which the read samples the array.
  task automatic do_pair(input int d, input logic [7:0] wa, input logic [7:0] wd, input logic [7:0] ra);
    logic [7:0] rexp;
    if ((ra == wa) && ((d + RL) >= WL)) rexp = wd;
    else                                 rexp = data_ref[ra];
    data_ref[wa] = wd;
    fork
      begin
        if (d < 0) repeat (-d) @(negedge clk);
        do_write(wa, wd);
      end
      begin
        if (d > 0) repeat (d) @(negedge clk);
        do_data_read(ra, rexp);
      end
    join
  endtask

  task automatic host_write(input logic sel, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    host_en    = 1'b1;
    host_sel   = sel;
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    if (sel) prog_ref[a] = d;
    else     data_ref[a] = d[7:0];
  endtask

  task automatic host_idle();
    @(negedge clk);
    host_we = 1'b0;
    host_en = 1'b0;
  endtask

  initial begin
    int         d;
    logic [7:0] a, b, wd;
    exp_t       e;

    reset = 1'b1;
    host_en = 1'b0; host_sel = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0;
    mem_if.program_mem_read_valid = 1'b0; mem_if.program_mem_read_address = '0;
    mem_if.data_mem_read_valid    = 1'b0; mem_if.data_mem_read_address    = '0;
    mem_if.data_mem_write_valid   = 1'b0; mem_if.data_mem_write_address   = '0;
    mem_if.data_mem_write_data    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check_output("reset_prog_ready", {31'h0, mem_if.program_mem_read_ready}, 32'h0);
    check_output("reset_rd_ready",   {31'h0, mem_if.data_mem_read_ready}, 32'h0);
    check_output("reset_wr_ready",   {31'h0, mem_if.data_mem_write_ready}, 32'h0);
    check_output("reset_prog_data",  mem_if.program_mem_read_data, 32'h0);
    check_output("reset_rd_data",    {24'h0, mem_if.data_mem_read_data}, 32'h0);
    check_output("reset_busy",       {31'h0, busy}, 32'h0);

    // Preload: data array cleared, program array random with known 0..3.
    for (int i = 0; i < 256; i++) host_write(1'b0, 8'(i), 32'h0);
    for (int i = 0; i < 256; i++) host_write(1'b1, 8'(i), $urandom);
    host_write(1'b1, 8'd0, 32'h11111111);
    host_write(1'b1, 8'd1, 32'h22222222);
    host_write(1'b1, 8'd2, 32'h33333333);
    host_write(1'b1, 8'd3, 32'h44444444);
    host_idle();

    do_prog_read(8'd2);

    data_ref[8'h10] = 8'hA5;
    do_write(8'h10, 8'hA5);
    do_data_read(8'h10, data_ref[8'h10]);

    do_pair(0, 8'd5, 8'h3C, 8'd5);

    // Reset while a write to address 7 waits to commit.
    @(negedge clk);
    mem_if.data_mem_write_valid   = 1'b1;
    mem_if.data_mem_write_address = 8'd7;
    mem_if.data_mem_write_data    = 8'hFF;
    e.data = 32'h0; e.due = cyc + 1 + WL;
    q_wr.push_back(e);
    @(negedge clk);
    check_output("busy_inflight", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    check_output("rst_wr_ready", {31'h0, mem_if.data_mem_write_ready}, 32'h0);
    check_output("rst_busy",     {31'h0, busy}, 32'h0);
    check_output("rst_rd_data",  {24'h0, mem_if.data_mem_read_data}, 32'h0);
    mem_if.data_mem_write_valid = 1'b0;
    q_wr.delete();
    @(negedge clk);
    reset = 1'b0;
    do_data_read(8'd7, data_ref[8'd7]);

    // host_en blocks acceptance of a pending read.
    @(negedge clk);
    host_en = 1'b1;
    mem_if.data_mem_read_valid   = 1'b1;
    mem_if.data_mem_read_address = 8'h10;
    repeat (3) begin
      @(negedge clk);
      check_output("blocked_busy",  {31'h0, busy}, 32'h0);
      check_output("blocked_ready", {31'h0, mem_if.data_mem_read_ready}, 32'h0);
    end
    host_en = 1'b0;
    e.data = {24'h0, data_ref[8'h10]}; e.due = cyc + 1 + RL;
    q_rd.push_back(e);
    finish_request(1);

    do_prog_read(8'd0);
    do_prog_read(8'd1);
    do_prog_read(8'd2);

    // Host and core write the same data address on the same edge.
    data_ref[8'h20] = 8'h5A;
    fork
      do_write(8'h20, 8'h5A);
      begin
        @(negedge clk);
        @(negedge clk);
        host_en = 1'b1; host_we = 1'b1; host_sel = 1'b0;
        host_addr = 8'h20; host_wdata = 32'h000000C3;
        @(negedge clk);
        host_we = 1'b0; host_en = 1'b0;
      end
    join
    do_data_read(8'h20, data_ref[8'h20]);

    do_pair(-1, 8'd9, 8'h77, 8'd9);
    do_pair(-2, 8'd9, 8'h88, 8'd9);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 5))
        0: do_prog_read(8'($urandom));
        1: begin
          a = 8'($urandom);
          do_data_read(a, data_ref[a]);
        end
        2: begin
          a = 8'($urandom); wd = 8'($urandom);
          data_ref[a] = wd;
          do_write(a, wd);
        end
        3: begin
          d  = int'($urandom_range(0, 4)) - 2;
          a  = 8'($urandom_range(0, 7));
          b  = ($urandom_range(0, 1) == 1) ? a : 8'($urandom_range(0, 7));
          wd = 8'($urandom);
          do_pair(d, a, wd, b);
        end
        4: begin
          host_write(1'($urandom), 8'($urandom), $urandom);
          host_idle();
        end
        default: begin
          a = 8'($urandom); b = 8'($urandom);
          fork
            do_prog_read(a);
            do_data_read(b, data_ref[b]);
          join
        end
      endcase
    end

    repeat (5) @(negedge clk);
    check_output("prog_queue_left", 32'(q_prog.size()), 32'h0);
    check_output("rd_queue_left",   32'(q_rd.size()), 32'h0);
    check_output("wr_queue_left",   32'(q_wr.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_mem_responder.md
Name: core_mem_responder

Overview:
- Memory-side responder for one compute core's three valid/ready channels: program read, data read and data write.
- Holds a program ROM-style array and a data RAM array.
- Answers each core request after a parameterised latency with a single-cycle ready pulse.
- Sits between the core and the top-level/bench; a host preload port fills both arrays before the core is started.

Parameters:
DATA_MEM_ADDR_BITS, 8, data memory address width (depth 2^N)
DATA_MEM_DATA_BITS, 8, data word width
PROGRAM_MEM_ADDR_BITS, 8, program memory address width (depth 2^N)
PROGRAM_MEM_DATA_BITS, 32, instruction width
PROG_LATENCY, 2, cycles from request acceptance to ready pulse, program channel (>=1)
READ_LATENCY, 2, same, data read channel (>=1)
WRITE_LATENCY, 1, same, data write channel (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
program_mem_read_valid  in  1  core program read request, held until served
program_mem_read_address  in  PROGRAM_MEM_ADDR_BITS  program address
program_mem_read_ready  out  1  one-cycle response pulse
program_mem_read_data  out  PROGRAM_MEM_DATA_BITS  instruction, valid while ready=1
data_mem_read_valid  in  1  core data read request
data_mem_read_address  in  DATA_MEM_ADDR_BITS  read address
data_mem_read_ready  out  1  one-cycle response pulse
data_mem_read_data  out  DATA_MEM_DATA_BITS  read data, valid while ready=1
data_mem_write_valid  in  1  core data write request
data_mem_write_address  in  DATA_MEM_ADDR_BITS  write address
data_mem_write_data  in  DATA_MEM_DATA_BITS  write data
data_mem_write_ready  out  1  one-cycle write-done pulse
host_en  in  1  host owns memories; blocks new core request acceptance
host_sel  in  1  0=data memory, 1=program memory
host_we  in  1  host write strobe
host_addr  in  PROGRAM_MEM_ADDR_BITS  host address (low DATA_MEM_ADDR_BITS bits used for data memory)
host_wdata  in  PROGRAM_MEM_DATA_BITS  host data (low DATA_MEM_DATA_BITS bits used for data memory)
busy  out  1  OR of all three channels not in IDLE

Behaviour:
- Reset: all ready outputs, read data outputs, busy and latency counters go to 0; all FSMs go to IDLE. Array contents are not cleared.
- Reset mid-operation: aborts all channels. An uncommitted write is dropped.
- Each channel has its own FSM with states IDLE, WAIT, RESP, DROP.
- IDLE -> WAIT: at an edge where valid=1 and host_en=0. That edge captures address (and write data), loads the counter with LATENCY-1, and is the acceptance edge t.
- WAIT: counter decrements each edge. At counter=0 -> RESP, so ready=1 during the cycle after edge t+LATENCY-1.
- Result: ready rises exactly LATENCY cycles after acceptance (LATENCY=1: ready high in cycle t+1).
- RESP lasts exactly 1 cycle.
  - Read channels: the registered array word at the captured address is on the data output during this cycle; data output returns to 0 afterwards.
  - Write channel: the array is updated at the edge entering RESP.
- RESP -> DROP.
- DROP -> IDLE at the first edge sampling valid=0. A valid still held high after ready is never served twice; the core must drop valid before a new request.
- Address/data changes after acceptance are ignored (captured values are used).
- Data read and data write may be accepted in the same cycle. A read sees the old or new value according to commit order:
  - a write committing on the same edge the read samples the array makes the new value visible to the read (write-first).
- Program and data channels are fully independent.
- Host port:
  - When host_we=1 and host_en=1, write host_wdata to the selected array at the edge.
  - host_we is ignored when host_en=0.
  - host_en=1 only blocks IDLE acceptance; in-flight requests complete.
  - A host data write and a core write commit to the same address on the same edge: the core write wins.
- Widths: no arithmetic. Addresses index arrays directly; truncation is as stated for the host port.

Test Plan:
- Reset, host_en=1; host-write program[0..3]=32'h11111111..32'h44444444; release host_en; program read addr 2 held high -> ready pulses once 2 cycles after acceptance with data 32'h33333333; no second pulse while valid is still high; ready=0 after.
- Data write addr 8'h10 data 8'hA5 -> write_ready 1 cycle after acceptance; later data read addr 8'h10 -> read_data 8'hA5 with ready 2 cycles after acceptance.
- Same-cycle data write addr 5 = 8'h3C and read addr 5 (old 8'h00) -> write_ready at t+1; read returns 8'h3C at t+2 (write-first).
- Assert reset during WAIT of a write to addr 7 = 8'hFF -> all outputs 0 immediately; subsequent read addr 7 returns the old value 8'h00.
- host_en=1 while a core read is pending in IDLE -> no acceptance and busy=0; drop host_en -> accepted next edge, ready after READ_LATENCY.
- Back-to-back program reads addr 0,1,2 with valid dropped for one cycle between them -> three ready pulses with correct instructions, each exactly PROG_LATENCY after its acceptance.
